// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions for the FCS transmit/receive blocks:
// seed, RX residue, polynomial, byte reversal and the TX FSM state enum.
package crc32_pkg;

  localparam logic [31:0] CRC32_SEED    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    FCS_A,
    FCS_LAST
  } tx_state_t;

  // Bit reversal within a byte so that wire bit0 enters the MSB-first datapath first.
  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) r[i] = b[7 - i];
    return r;
  endfunction

  // One FCS wire byte from an 8-bit slice of the final CRC register.
  function automatic logic [7:0] fcs_byte(input logic [7:0] c);
    return ~rev8(c);
  endfunction

endpackage

// File: rtl/crc32_fcs_tx_if.sv
// Stream interface for crc32_fcs_tx: input frame stream and output frame stream.
interface crc32_fcs_tx_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_odd;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_odd;
  logic        out_ready;

  modport slave (
    input  in_data, in_valid, in_last, in_odd, out_ready,
    output in_ready, out_data, out_valid, out_last, out_odd
  );

  modport master (
    output in_data, in_valid, in_last, in_odd, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_odd
  );
endinterface

// File: rtl/crc32_d16.sv
// CRC-32 (poly 0x04C11DB7, MSB first) advanced by one 16-bit word.
module crc32_d16
  import crc32_pkg::*;
(
  input  logic [15:0] data_in,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);

  // Bit-serial unrolled step, data_in[15] processed first.
  always_comb begin
    crc_out = crc_in;
    for (int unsigned i = 0; i < 16; i++) begin
      if (crc_out[31] ^ data_in[15 - i]) crc_out = {crc_out[30:0], 1'b0} ^ CRC32_POLY;
      else                               crc_out = {crc_out[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/crc32_d8.sv
// CRC-32 (poly 0x04C11DB7, MSB first) advanced by one byte; used for the odd tail.
module crc32_d8
  import crc32_pkg::*;
(
  input  logic [7:0]  data_in,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);

  // Bit-serial unrolled step, data_in[7] processed first.
  always_comb begin
    crc_out = crc_in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (crc_out[31] ^ data_in[7 - i]) crc_out = {crc_out[30:0], 1'b0} ^ CRC32_POLY;
      else                              crc_out = {crc_out[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/crc32_fcs_tx.sv
// Transmit-side Ethernet FCS sequencer: passes a 16-bit frame stream through a
// single registered stage and appends the 4-byte CRC-32 FCS.
// Optional feature: define CRC32_TX_BYPASS_EN to add the per-frame `bypass` input.
module crc32_fcs_tx
  import crc32_pkg::*;
(
  input logic           sys_clk,
  input logic           sys_rst,
`ifdef CRC32_TX_BYPASS_EN
  input logic           bypass,
`endif
  crc32_fcs_tx_if.slave bus
);

  tx_state_t   state, state_next;
  logic [31:0] crc, crc_next, crc_w, crc_b;
  logic        odd_frame, odd_frame_next;
  logic [15:0] out_data_next;
  logic        out_valid_next, out_last_next, out_odd_next;
  logic        slot_free, in_ready, in_fire, byp;
  logic [7:0]  b0, b1, b0_rev, b1_rev;

  assign b0     = bus.in_data[7:0];
  assign b1     = bus.in_data[15:8];
  assign b0_rev = rev8(b0);
  assign b1_rev = rev8(b1);

  crc32_d16 u_d16 (.data_in({b0_rev, b1_rev}), .crc_in(crc), .crc_out(crc_w));
  crc32_d8  u_d8  (.data_in(b0_rev),           .crc_in(crc), .crc_out(crc_b));

  assign slot_free    = !bus.out_valid || bus.out_ready;
  assign in_ready     = (state == IDLE || state == DATA) && slot_free && !sys_rst;
  assign bus.in_ready = in_ready;
  assign in_fire      = bus.in_valid && in_ready;

`ifdef CRC32_TX_BYPASS_EN
  logic bypass_q;
  // The first word of a frame uses the live pin; later words use the captured value.
  assign byp = (state == IDLE) ? bypass : bypass_q;

  // Capture bypass on the first accepted word of each frame.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                       bypass_q <= 1'b0;
    else if (in_fire && state == IDLE) bypass_q <= bypass;
  end
`else
  assign byp = 1'b0;
`endif

  // Next-state, CRC stepping and output-register load.
  always_comb begin
    state_next     = state;
    crc_next       = crc;
    odd_frame_next = odd_frame;
    out_data_next  = bus.out_data;
    out_valid_next = bus.out_valid && !bus.out_ready;
    out_last_next  = bus.out_last;
    out_odd_next   = bus.out_odd;
    case (state)
      IDLE, DATA: begin
        if (in_fire) begin
          out_valid_next = 1'b1;
          out_data_next  = bus.in_data;
          out_last_next  = 1'b0;
          out_odd_next   = 1'b0;
          if (byp) begin
            out_last_next = bus.in_last;
            out_odd_next  = bus.in_last && bus.in_odd;
            state_next    = bus.in_last ? IDLE : DATA;
          end else if (bus.in_last) begin
            odd_frame_next = bus.in_odd;
            state_next     = FCS_A;
            if (bus.in_odd) begin
              // Odd tail: the free upper lane already carries fcs0.
              crc_next      = crc_b;
              out_data_next = {fcs_byte(crc_b[31:24]), b0};
            end else begin
              crc_next = crc_w;
            end
          end else begin
            crc_next   = crc_w;
            state_next = DATA;
          end
        end
      end
      FCS_A: begin
        if (slot_free) begin
          out_valid_next = 1'b1;
          out_last_next  = 1'b0;
          out_odd_next   = 1'b0;
          out_data_next  = odd_frame ? {fcs_byte(crc[15:8]),  fcs_byte(crc[23:16])}
                                     : {fcs_byte(crc[23:16]), fcs_byte(crc[31:24])};
          state_next     = FCS_LAST;
        end
      end
      FCS_LAST: begin
        if (slot_free) begin
          out_valid_next = 1'b1;
          out_last_next  = 1'b1;
          out_odd_next   = odd_frame;
          out_data_next  = odd_frame ? {8'h00, fcs_byte(crc[7:0])}
                                     : {fcs_byte(crc[7:0]), fcs_byte(crc[15:8])};
          crc_next       = CRC32_SEED;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        crc_next   = CRC32_SEED;
      end
    endcase
  end

  // State, CRC and output register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= IDLE;
      crc           <= CRC32_SEED;
      odd_frame     <= 1'b0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_odd   <= 1'b0;
    end else begin
      state         <= state_next;
      crc           <= crc_next;
      odd_frame     <= odd_frame_next;
      bus.out_data  <= out_data_next;
      bus.out_valid <= out_valid_next;
      bus.out_last  <= out_last_next;
      bus.out_odd   <= out_odd_next;
    end
  end

endmodule
